// File: rtl/maxpool_pkg.sv
// Shared defaults, FSM state type and counter-width helper for the 3x3 max-pool
// window generator.
package maxpool_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// One image row of storage, addressed by column: the old word at an address is
// visible combinationally while the new word is written on the same edge.
module maxpool_line_buffer
    import maxpool_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int AW        = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    assign rd_data_o = mem_q[addr_i];

    // Contents are deliberately unreset: every word is rewritten before it is consumed.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/maxpool_window_3x3.sv
// Raster-to-3x3-window stage feeding the max-pool comparator tree.
// Define MAXPOOL_STRIDE2_EN to emit only windows whose newest pixel has even row and col.
module maxpool_window_3x3
    import maxpool_pkg::*;
#(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDTH-1:0] Data_Out0,
    output logic [DATA_WIDTH-1:0] Data_Out1,
    output logic [DATA_WIDTH-1:0] Data_Out2,
    output logic [DATA_WIDTH-1:0] Data_Out3,
    output logic [DATA_WIDTH-1:0] Data_Out4,
    output logic [DATA_WIDTH-1:0] Data_Out5,
    output logic [DATA_WIDTH-1:0] Data_Out6,
    output logic [DATA_WIDTH-1:0] Data_Out7,
    output logic [DATA_WIDTH-1:0] Data_Out8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

`ifdef MAXPOOL_STRIDE2_EN
    localparam logic [CW-1:0] DONE_COL = CW'(((IMG_WIDTH - 1) / 2) * 2);
    localparam logic [RW-1:0] DONE_ROW = RW'(((IMG_HEIGHT - 1) / 2) * 2);
`else
    localparam logic [CW-1:0] DONE_COL = COL_LAST;
    localparam logic [RW-1:0] DONE_ROW = ROW_LAST;
`endif

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] win_q [0:8];
    logic [DATA_WIDTH-1:0] win_d [0:8];
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_a_s, rd_b_s;
    logic                  col_wrap_s, row_wrap_s, stride_ok_s, emit_s;

    // A holds the previous row; B receives A's displaced word and so holds the row before that.
    maxpool_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_row_a (
        .clk       (clk),
        .we_i      (Valid_In & ~rst),
        .addr_i    (col_q),
        .wr_data_i (Data_In),
        .rd_data_o (rd_a_s)
    );

    maxpool_line_buffer #(.DEPTH(IMG_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_row_b (
        .clk       (clk),
        .we_i      (Valid_In & ~rst),
        .addr_i    (col_q),
        .wr_data_i (rd_a_s),
        .rd_data_o (rd_b_s)
    );

    assign col_wrap_s = (col_q == COL_LAST);
    assign row_wrap_s = (row_q == ROW_LAST);

`ifdef MAXPOOL_STRIDE2_EN
    assign stride_ok_s = ~col_q[0] & ~row_q[0];
`else
    assign stride_ok_s = 1'b1;
`endif

    assign emit_s = Valid_In && (state_q == STREAM) && (col_q >= COL_TWO) && stride_ok_s;

    // Raster position and FILL/STREAM phase, advanced per accepted pixel.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        if (Valid_In) begin
            if (col_wrap_s) begin
                col_d = '0;
                if (row_wrap_s) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
            case (state_q)
                FILL: begin
                    if (col_wrap_s && (row_q == ROW_ONE)) begin
                        state_d = STREAM;
                    end else begin
                        state_d = FILL;
                    end
                end
                STREAM: begin
                    if (col_wrap_s && row_wrap_s) begin
                        state_d = FILL;
                    end else begin
                        state_d = STREAM;
                    end
                end
                default: state_d = FILL;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Window shifts left; new right column is {two rows up, one row up, incoming pixel}.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            win_d[k] = win_q[k];
        end
        if (Valid_In) begin
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = rd_b_s;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = rd_a_s;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = Data_In;
        end else begin
            win_d[8] = win_q[8];
        end
        valid_d = emit_s;
        done_d  = emit_s && (col_q == DONE_COL) && (row_q == DONE_ROW);
    end

    // State registers; reset also discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= FILL;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            state_q <= state_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

    assign Data_Out0  = win_q[0];
    assign Data_Out1  = win_q[1];
    assign Data_Out2  = win_q[2];
    assign Data_Out3  = win_q[3];
    assign Data_Out4  = win_q[4];
    assign Data_Out5  = win_q[5];
    assign Data_Out6  = win_q[6];
    assign Data_Out7  = win_q[7];
    assign Data_Out8  = win_q[8];
    assign Valid_Out  = valid_q;
    assign Frame_Done = done_q;

endmodule

// File: tb/tb_maxpool_window_3x3.sv
// Bench for maxpool_window_3x3: a 4x4 instance and a larger instance, each
// checked every cycle against a frame-array model, plus literal window pins.
module tb_maxpool_window_3x3;

`ifdef MAXPOOL_STRIDE2_EN
    localparam bit S2 = 1'b1;
    localparam int W1 = 6;
    localparam int N4 = 1;
`else
    localparam bit S2 = 1'b0;
    localparam int W1 = 8;
    localparam int N4 = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din [0:1];
    logic        vin [0:1];
    int          checks = 0;
    int          errors = 0;

    int ends4  [0:3] = '{11, 12, 15, 16};
    int first4 [0:8] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W  = (g == 0) ? 4 : W1;
        localparam int H  = W;
        localparam int LR = S2 ? ((H - 1) / 2) * 2 : H - 1;
        localparam int LC = S2 ? ((W - 1) / 2) * 2 : W - 1;

        logic [31:0] dout [0:8];
        logic        vo, fd;
        logic [31:0] img [0:H-1][0:W-1];
        logic [31:0] exp_w [0:8];
        logic        exp_v = 1'b0, exp_d = 1'b0, exp_zero = 1'b0, live = 1'b0;
        int          r = 0, c = 0;
        logic [31:0] wlog [0:127][0:8];
        logic        dlog [0:127];
        int          nwin = 0;

        maxpool_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(32)) u_dut (
            .clk(clk), .rst(rst), .Data_In(din[g]), .Valid_In(vin[g]),
            .Data_Out0(dout[0]), .Data_Out1(dout[1]), .Data_Out2(dout[2]),
            .Data_Out3(dout[3]), .Data_Out4(dout[4]), .Data_Out5(dout[5]),
            .Data_Out6(dout[6]), .Data_Out7(dout[7]), .Data_Out8(dout[8]),
            .Valid_Out(vo), .Frame_Done(fd)
        );

        // Model: the frame as a 2-D array; a window is the 3x3 block ending at the new pixel.
        initial forever begin
            @(posedge clk);
            exp_zero = rst;
            exp_v    = 1'b0;
            exp_d    = 1'b0;
            if (rst) begin
                r    = 0;
                c    = 0;
                live = 1'b1;
            end else if (vin[g] === 1'b1) begin
                if (r >= 2 && c >= 2 && (!S2 || (r % 2 == 0 && c % 2 == 0))) begin
                    exp_v = 1'b1;
                    exp_d = (r == LR && c == LC);
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            exp_w[i*3+j] = (i == 2 && j == 2) ? din[g] : img[r-2+i][c-2+j];
                end
                img[r][c] = din[g];
                if (c == W - 1) begin
                    c = 0;
                    r = (r == H - 1) ? 0 : r + 1;
                end else begin
                    c++;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (live) begin
                chk($sformatf("valid_g%0d", g), 32'(vo), 32'(exp_v));
                chk($sformatf("done_g%0d", g), 32'(fd), 32'(exp_d));
                for (int k = 0; k < 9; k++) begin
                    if (exp_v) chk($sformatf("win_g%0d_w%0d", g, k), dout[k], exp_w[k]);
                    if (exp_zero) chk($sformatf("rstzero_g%0d_w%0d", g, k), dout[k], 32'd0);
                end
                if (vo === 1'b1 && nwin < 128) begin
                    for (int k = 0; k < 9; k++) wlog[nwin][k] = dout[k];
                    dlog[nwin] = fd;
                    nwin++;
                end
            end
        end
    end

    task automatic send(input int g, input logic [31:0] v, input int gap);
        @(negedge clk);
        din[g] = v;
        vin[g] = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            vin[g] = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        vin[0] = 1'b0;
        vin[1] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame4(input int off, input int gap);
        for (int p = 1; p <= 16; p++) send(0, 32'(p + off), gap);
    endtask

    // Pins the 4x4 windows starting at log index base against hand-computed values.
    task automatic check4(input string tag, input int base, input int off);
        for (int k = 0; k < N4; k++) begin
            chk($sformatf("%s_end%0d", tag, k), g_dut[0].wlog[base+k][8], 32'(ends4[k] + off));
            chk($sformatf("%s_done%0d", tag, k), 32'(g_dut[0].dlog[base+k]), 32'(k == N4 - 1));
        end
        for (int k = 0; k < 9; k++)
            chk($sformatf("%s_first_w%0d", tag, k), g_dut[0].wlog[base][k], 32'(first4[k] + off));
    endtask

    initial begin
        int base;
        int ndone;
        din[0] = 32'd0; din[1] = 32'd0;
        vin[0] = 1'b0;  vin[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_valid", 32'(g_dut[0].vo), 32'd0);
        chk("reset_dout4", g_dut[0].dout[4], 32'd0);

        base = g_dut[0].nwin;
        send_frame4(0, 0);
        idle(3);
        chk("t1_count", 32'(g_dut[0].nwin - base), 32'(N4));
        check4("t1", base, 0);

        base = g_dut[0].nwin;
        send_frame4(0, 1);
        idle(3);
        chk("t2_count", 32'(g_dut[0].nwin - base), 32'(N4));
        check4("t2", base, 0);

        base = g_dut[0].nwin;
        send_frame4(0, 0);
        send_frame4(100, 0);
        idle(3);
        chk("t3_count", 32'(g_dut[0].nwin - base), 32'(2 * N4));
        check4("t3a", base, 0);
        check4("t3b", base + N4, 100);

        base = g_dut[0].nwin;
        for (int p = 1; p <= 10; p++) send(0, 32'(p), 0);
        @(negedge clk);
        rst    = 1'b1;
        din[0] = 32'd11;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t4_rst_valid", 32'(g_dut[0].vo), 32'd0);
        chk("t4_rst_dout8", g_dut[0].dout[8], 32'd0);
        send_frame4(0, 0);
        idle(3);
        chk("t4_count", 32'(g_dut[0].nwin - base), 32'(N4));
        check4("t4", base, 0);

        base = g_dut[1].nwin;
`ifdef MAXPOOL_STRIDE2_EN
        for (int p = 1; p <= 36; p++) send(1, 32'(p), 0);
        idle(3);
        chk("s2_count", 32'(g_dut[1].nwin - base), 32'd4);
        chk("s2_end0", g_dut[1].wlog[base][8], 32'd15);
        chk("s2_end1", g_dut[1].wlog[base+1][8], 32'd17);
        chk("s2_end2", g_dut[1].wlog[base+2][8], 32'd27);
        chk("s2_end3", g_dut[1].wlog[base+3][8], 32'd29);
        chk("s2_done3", 32'(g_dut[1].dlog[base+3]), 32'd1);
        chk("s2_done0", 32'(g_dut[1].dlog[base]), 32'd0);
        chk("s2_first_w0", g_dut[1].wlog[base][0], 32'd1);
        chk("s2_first_w3", g_dut[1].wlog[base][3], 32'd7);
        chk("s2_first_w5", g_dut[1].wlog[base][5], 32'd9);
        chk("s2_first_w6", g_dut[1].wlog[base][6], 32'd13);
`else
        for (int p = 0; p < 64; p++) send(1, $urandom, $urandom_range(0, 2));
        idle(3);
        chk("rand_count", 32'(g_dut[1].nwin - base), 32'd36);
        ndone = 0;
        for (int k = base; k < g_dut[1].nwin; k++) ndone += int'(g_dut[1].dlog[k]);
        chk("rand_done_count", 32'(ndone), 32'd1);
        chk("rand_done_last", 32'(g_dut[1].dlog[base+35]), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
